tile_cfg_loader: RTL and testbench

- Configuration front-end that sits directly upstream of the tile array and drives each tile's wr_en/bits configuration port.
- Accepts a byte-wide framed bitstream over a valid/ready handshake.
- Assembles each 77-bit tile configuration word, checks it, and issues a one-cycle write to the addressed tile.
- One loader serves NUM_TILES tiles. All tiles share the bits bus; wr_en is one-hot per tile.

---
 rtl/tile_cfg_loader_if.sv | 27 ++
 rtl/tile_cfg_loader.sv | 160 ++++++++++++++++
 tb/tb_tile_cfg_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tile_cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : tile_cfg_loader_if
//  Description : Byte-wide valid/ready stream carrying the framed tile
//                configuration bitstream into tile_cfg_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tile_cfg_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Bitstream source side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/tile_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tile_cfg_loader
//  Description : Receives SYNC/ADDR/payload/CHK frames over a byte stream,
//                assembles a CFG_BITS configuration word, verifies the XOR
//                checksum and address, and issues a one-cycle one-hot write
//                to the addressed tile on a shared bits bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_cfg_loader #(
    parameter int         NUM_TILES = 4,
    parameter int         CFG_BITS  = 77,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    tile_cfg_loader_if.slave          in_bus,
    output logic [NUM_TILES-1:0]      wr_en,
    output logic [CFG_BITS-1:0]       bits,
    output logic                      err,
    output logic [7:0]                cfg_count
);

    // Payload byte count and its index width
    localparam int                NBYTES     = (CFG_BITS + 7) / 8;
    localparam int                CNT_W      = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0]  C_LAST_IDX = CNT_W'(NBYTES - 1);
    // Addresses are a single byte, so the tile limit is compared as a byte
    localparam logic [7:0]        C_TILE_LIM = 8'(NUM_TILES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_ready;
    logic                  w_xfer;
    logic                  w_go_write;
    logic                  w_reject;
    logic [7:0]            r_addr;
    logic [7:0]            r_acc;
    logic [CNT_W-1:0]      r_cnt;
    // Only the low CFG_BITS of the shifted payload are ever used, so the
    // padding bits of the first byte simply fall off the top.
    logic [CFG_BITS-1:0]   r_sr;
    logic [NUM_TILES-1:0]  w_dec;

    assign in_bus.in_ready = r_ready;
    assign w_xfer          = in_bus.in_valid & r_ready;

    // One-hot decode of the latched tile address
    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_wr_dec
        assign w_dec[gi] = (r_addr == 8'(gi));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and write/reject decisions
    always_comb begin
        w_next     = r_state;
        w_go_write = 1'b0;
        w_reject   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Anything other than the sync marker is silently dropped
                if (w_xfer && (in_bus.in_data == SYNC_BYTE)) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_xfer) begin
                    w_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_xfer && (r_cnt == C_LAST_IDX)) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_xfer) begin
                    // Bad address still consumes the full frame to keep alignment
                    if ((in_bus.in_data == r_acc) && (r_addr < C_TILE_LIM)) begin
                        w_next     = S_WRITE;
                        w_go_write = 1'b1;
                    end else begin
                        w_next   = S_IDLE;
                        w_reject = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Ready is registered so it is low throughout reset and during WRITE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_next != S_WRITE);
        end
    end

    // Frame assembly: address latch, payload shift register, checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sr   <= '0;
        end else if (w_xfer) begin
            if (r_state == S_ADDR) begin
                r_addr <= in_bus.in_data;
                r_acc  <= in_bus.in_data;
                r_cnt  <= '0;
            end else if (r_state == S_PAYLOAD) begin
                r_sr   <= {r_sr[CFG_BITS-9:0], in_bus.in_data};
                r_acc  <= r_acc ^ in_bus.in_data;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // Tile-facing outputs; bits and wr_en move together on the CHK edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= '0;
            bits      <= '0;
            err       <= 1'b0;
            cfg_count <= '0;
        end else begin
            wr_en <= w_go_write ? w_dec : '0;
            err   <= w_reject;
            if (w_go_write) begin
                bits      <= r_sr;
                cfg_count <= cfg_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_cfg_loader
//  Description : Directed self-checking bench for tile_cfg_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_cfg_loader;

    localparam int NUM_TILES = 4;
    localparam int CFG_BITS  = 77;

    logic                 clk;
    logic                 reset;
    logic [NUM_TILES-1:0] wr_en;
    logic [CFG_BITS-1:0]  bits;
    logic                 err;
    logic [7:0]           cfg_count;

    tile_cfg_loader_if bus ();

    tile_cfg_loader #(
        .NUM_TILES (NUM_TILES),
        .CFG_BITS  (CFG_BITS),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (bus),
        .wr_en     (wr_en),
        .bits      (bits),
        .err       (err),
        .cfg_count (cfg_count)
    );

    int checks     = 0;
    int errors     = 0;
    int wr_pulses  = 0;
    int err_pulses = 0;
    bit mon_on     = 1'b0;
    bit gap_mode   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts write/err cycles and checks ready is low exactly in the write cycle
    always @(posedge clk) begin
        if (mon_on) begin
            if (wr_en != '0) wr_pulses++;
            if (err) err_pulses++;
            checks++;
            assert (bus.in_ready === ~|wr_en) else begin
                errors++;
                $error("FAIL ready_vs_write: observed ready=%b wr_en=%b", bus.in_ready, wr_en);
            end
        end
    end

    // Must be called at a negedge; returns at the negedge after the transfer
    task automatic send(input logic [7:0] b);
        int waited = 0;
        if (gap_mode && ($urandom_range(0, 1) == 1)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while ((bus.in_ready !== 1'b1) && (waited < 20)) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", {79'd0, bus.in_ready}, 80'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [79:0] pl, input logic [7:0] flip);
        logic [7:0] chk;
        chk = addr;
        send(8'hA5);
        send(addr);
        for (int k = 0; k < 10; k++) begin
            chk = chk ^ pl[79-8*k -: 8];
            send(pl[79-8*k -: 8]);
        end
        send(chk ^ flip);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, er0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", {79'd0, bus.in_ready}, 80'd0);
        check("rst_wr_en", {76'd0, wr_en}, 80'd0);
        check("rst_bits",  {3'd0, bits}, 80'd0);
        check("rst_err",   {79'd0, err}, 80'd0);
        check("rst_count", {72'd0, cfg_count}, 80'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_release", {79'd0, bus.in_ready}, 80'd1);
        mon_on = 1'b1;

        // Frame 1: addr 1, payload value 1
        send_frame(8'h01, 80'h1, 8'h00);
        check("f1_wr_en", {76'd0, wr_en}, 80'b0010);
        check("f1_bits",  {3'd0, bits}, 80'd1);
        check("f1_count", {72'd0, cfg_count}, 80'd1);
        check("f1_ready_low", {79'd0, bus.in_ready}, 80'd0);

        // Frame 2 starts during the WRITE cycle: addr 0, padding bits dropped
        send_frame(8'h00, 80'hFF << 72, 8'h00);
        check("f2_wr_en", {76'd0, wr_en}, 80'b0001);
        check("f2_bits",  {3'd0, bits}, {3'd0, 77'h1F << 72});
        check("f2_count", {72'd0, cfg_count}, 80'd2);
        @(negedge clk);
        check("f2_wr_drop", {76'd0, wr_en}, 80'd0);
        check("f12_pulses", wr_pulses, 2);
        check("f12_no_err", err_pulses, 0);

        // Frame 3: bad checksum to addr 2
        send_frame(8'h02, 80'h1234_5678_9ABC_DEF0_1234, 8'h01);
        check("f3_err",   {79'd0, err}, 80'd1);
        check("f3_wr_en", {76'd0, wr_en}, 80'd0);
        check("f3_bits",  {3'd0, bits}, {3'd0, 77'h1F << 72});
        check("f3_count", {72'd0, cfg_count}, 80'd2);
        @(negedge clk);
        check("f3_err_drop", {79'd0, err}, 80'd0);
        check("f3_err_pulses", err_pulses, 1);

        // Frame 4: out-of-range addr 7, then immediate good frame to addr 3
        wr0 = wr_pulses;
        send_frame(8'h07, 80'h0102_0304_0506_0708_090A, 8'h00);
        check("f4_err",   {79'd0, err}, 80'd1);
        check("f4_wr_en", {76'd0, wr_en}, 80'd0);
        send_frame(8'h03, 80'hE001_0203_0405_0607_0809, 8'h00);
        check("f5_wr_en", {76'd0, wr_en}, 80'b1000);
        check("f5_bits",  {3'd0, bits}, {3'd0, 77'h01_0203_0405_0607_0809});
        check("f5_count", {72'd0, cfg_count}, 80'd3);
        @(negedge clk);
        check("f45_pulses", wr_pulses - wr0, 1);
        check("f45_err_pulses", err_pulses, 2);

        // Frame 6: garbage, gaps, embedded A5 payload byte
        wr0 = wr_pulses;
        er0 = err_pulses;
        gap_mode = 1'b1;
        send(8'h12);
        send(8'h34);
        send_frame(8'h01, 80'h0011_A522_3344_5566_7788, 8'h00);
        check("f6_wr_en", {76'd0, wr_en}, 80'b0010);
        check("f6_bits",  {3'd0, bits}, {3'd0, 77'h11_A522_3344_5566_7788});
        check("f6_count", {72'd0, cfg_count}, 80'd4);
        gap_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("f6_pulses", wr_pulses - wr0, 1);
        check("f6_no_err", err_pulses - er0, 0);

        // Frame 7: reset after the 5th payload byte aborts the frame
        send(8'hA5);
        send(8'h00);
        for (int k = 0; k < 5; k++) send(8'h55);
        mon_on = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", {76'd0, wr_en}, 80'd0);
        check("mid_rst_bits",  {3'd0, bits}, 80'd0);
        check("mid_rst_err",   {79'd0, err}, 80'd0);
        check("mid_rst_count", {72'd0, cfg_count}, 80'd0);
        check("mid_rst_ready", {79'd0, bus.in_ready}, 80'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        wr0 = wr_pulses;
        er0 = err_pulses;
        send_frame(8'h02, 80'h0FEE_DDCC_BBAA_9988_7766, 8'h00);
        check("f8_wr_en", {76'd0, wr_en}, 80'b0100);
        check("f8_bits",  {3'd0, bits}, {3'd0, 77'h0F_EEDD_CCBB_AA99_8877_66});
        check("f8_count", {72'd0, cfg_count}, 80'd1);
        repeat (2) @(negedge clk);
        check("f8_pulses", wr_pulses - wr0, 1);
        check("f8_no_err", err_pulses - er0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
